// File: rtl/hand_flap_pkg.sv
// Shared types, image geometry and coordinate clamp helpers for the hand-flap controller.
package hand_flap_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRACK    = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    localparam int IMG_W = 320;
    localparam int IMG_H = 240;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;

    function automatic logic [X_W-1:0] clamp_x(input logic signed [31:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > IMG_W - 1) begin
            return X_W'(IMG_W - 1);
        end else begin
            return v[X_W-1:0];
        end
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic signed [31:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > IMG_H - 1) begin
            return Y_W'(IMG_H - 1);
        end else begin
            return v[Y_W-1:0];
        end
    endfunction

endpackage

// File: rtl/frame_strobe_sync.sv
// Brings the camera vsync into the clk domain and emits a one-cycle frame strobe
// on each vsync rising edge, three clock edges after the rise.
module frame_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync_i,
    output logic fs_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic fs_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            meta_q     <= vsync_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            fs_q       <= sync_q & ~sync_dly_q;
        end
    end

    assign fs_o = fs_q;

endmodule

// File: rtl/hand_flap_ctrl.sv
// Smooths per-frame hand centroids and turns an upward hand stroke into a one-cycle flap.
// Optional build macro HAND_FLAP_AUTOFLAP_EN adds a periodic auto-flap while no hand is tracked.
module hand_flap_ctrl
    import hand_flap_pkg::*;
#(
    parameter int AVG_DEPTH       = 4,
    parameter int FLAP_THRESH     = 12,
    parameter int COOLDOWN_FRAMES = 6,
    parameter int LOST_FRAMES     = 3,
    parameter int AUTO_FRAMES     = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        pos_valid,
    input  logic [31:0] x_position,
    input  logic [31:0] y_position,
    output logic        flap,
    output logic        hand_present,
    output logic [8:0]  x_smooth,
    output logic [7:0]  y_smooth,
    output logic [15:0] flap_cnt
);

    localparam int LOG2_AVG = $clog2(AVG_DEPTH);
    localparam int XS_W     = X_W + LOG2_AVG;
    localparam int YS_W     = Y_W + LOG2_AVG;
    localparam int CD_W     = $clog2(COOLDOWN_FRAMES + 1);
    localparam int MISS_W   = $clog2(LOST_FRAMES + 1);

    localparam logic [Y_W-1:0]    THRESH_Y  = Y_W'(FLAP_THRESH);
    localparam logic [CD_W-1:0]   CD_RELOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOST_FRAMES - 1);

    logic           fs;
    logic           auto_flap;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;

    state_t            state_q, state_d;
    logic [X_W-1:0]    win_x_q [AVG_DEPTH];
    logic [X_W-1:0]    win_x_d [AVG_DEPTH];
    logic [Y_W-1:0]    win_y_q [AVG_DEPTH];
    logic [Y_W-1:0]    win_y_d [AVG_DEPTH];
    logic [XS_W-1:0]   sum_x_q, sum_x_d;
    logic [YS_W-1:0]   sum_y_q, sum_y_d;
    logic [X_W-1:0]    x_smooth_q, x_smooth_d;
    logic [Y_W-1:0]    y_smooth_q, y_smooth_d;
    logic [Y_W-1:0]    prev_y_q, prev_y_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              cmp_pend_q, cmp_pend_d;
    logic              flap_q, flap_d;
    logic [15:0]       flap_cnt_q, flap_cnt_d;

    frame_strobe_sync u_fs_sync (
        .clk     (clk),
        .reset   (reset),
        .vsync_i (vsync_in),
        .fs_o    (fs)
    );

    assign cx = clamp_x(x_position);
    assign cy = clamp_y(y_position);

`ifdef HAND_FLAP_AUTOFLAP_EN
    localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_pend_q, auto_pend_d;

    always_comb begin
        auto_cnt_d  = auto_cnt_q;
        auto_pend_d = 1'b0;
        if (state_q != S_IDLE || (fs && pos_valid)) begin
            auto_cnt_d = '0;
        end else if (fs) begin
            if (auto_cnt_q == AUTO_W'(AUTO_FRAMES - 1)) begin
                auto_cnt_d  = '0;
                auto_pend_d = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt_q  <= '0;
            auto_pend_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_pend_q <= auto_pend_d;
        end
    end

    assign auto_flap = auto_pend_q;
`else
    assign auto_flap = 1'b0;
`endif

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        win_x_d    = win_x_q;
        win_y_d    = win_y_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        x_smooth_d = x_smooth_q;
        y_smooth_d = y_smooth_q;
        prev_y_d   = prev_y_q;
        miss_d     = miss_q;
        cd_d       = cd_q;
        cmp_pend_d = 1'b0;
        flap_d     = 1'b0;
        flap_cnt_d = flap_cnt_q;

        if (fs) begin
            prev_y_d = y_smooth_q;
            unique case (state_q)
                S_IDLE: begin
                    if (pos_valid) begin
                        win_x_d = '{default: cx};
                        win_y_d = '{default: cy};
                        sum_x_d = XS_W'(cx) << LOG2_AVG;
                        sum_y_d = YS_W'(cy) << LOG2_AVG;
                        miss_d  = '0;
                        cd_d    = '0;
                        state_d = S_TRACK;
                    end
                end
                S_TRACK, S_COOLDOWN: begin
                    if (pos_valid) begin
                        for (int i = AVG_DEPTH - 1; i > 0; i--) begin
                            win_x_d[i] = win_x_q[i-1];
                            win_y_d[i] = win_y_q[i-1];
                        end
                        win_x_d[0] = cx;
                        win_y_d[0] = cy;
                        sum_x_d    = sum_x_q + XS_W'(cx) - XS_W'(win_x_q[AVG_DEPTH-1]);
                        sum_y_d    = sum_y_q + YS_W'(cy) - YS_W'(win_y_q[AVG_DEPTH-1]);
                        miss_d     = '0;
                        cmp_pend_d = (state_q == S_TRACK);
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end

                    if (state_q == S_COOLDOWN) begin
                        cd_d = cd_q - 1'b1;
                        if (cd_q == CD_W'(1)) begin
                            state_d = S_TRACK;
                        end
                    end

                    // Losing the hand overrides cooldown expiry on the same frame.
                    if (!pos_valid && miss_q == MISS_LAST) begin
                        state_d  = S_IDLE;
                        win_x_d  = '{default: '0};
                        win_y_d  = '{default: '0};
                        sum_x_d  = '0;
                        sum_y_d  = '0;
                        prev_y_d = '0;
                        miss_d   = '0;
                        cd_d     = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (state_d == S_IDLE) begin
                x_smooth_d = '0;
                y_smooth_d = '0;
            end else begin
                x_smooth_d = X_W'(sum_x_d >> LOG2_AVG);
                y_smooth_d = Y_W'(sum_y_d >> LOG2_AVG);
            end
        end else begin
            if (cmp_pend_q && prev_y_q > y_smooth_q && (prev_y_q - y_smooth_q) >= THRESH_Y) begin
                flap_d     = 1'b1;
                flap_cnt_d = flap_cnt_q + 16'd1;
                state_d    = S_COOLDOWN;
                cd_d       = CD_RELOAD;
            end else if (auto_flap) begin
                flap_d     = 1'b1;
                flap_cnt_d = flap_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: the window arrays are reset too, since the running sums are only valid alongside them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            win_x_q    <= '{default: '0};
            win_y_q    <= '{default: '0};
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            x_smooth_q <= '0;
            y_smooth_q <= '0;
            prev_y_q   <= '0;
            miss_q     <= '0;
            cd_q       <= '0;
            cmp_pend_q <= 1'b0;
            flap_q     <= 1'b0;
            flap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            win_x_q    <= win_x_d;
            win_y_q    <= win_y_d;
            sum_x_q    <= sum_x_d;
            sum_y_q    <= sum_y_d;
            x_smooth_q <= x_smooth_d;
            y_smooth_q <= y_smooth_d;
            prev_y_q   <= prev_y_d;
            miss_q     <= miss_d;
            cd_q       <= cd_d;
            cmp_pend_q <= cmp_pend_d;
            flap_q     <= flap_d;
            flap_cnt_q <= flap_cnt_d;
        end
    end

    assign flap         = flap_q;
    assign hand_present = (state_q != S_IDLE);
    assign x_smooth     = x_smooth_q;
    assign y_smooth     = y_smooth_q;
    assign flap_cnt     = flap_cnt_q;

endmodule

// File: tb/tb_hand_flap_ctrl.sv
// Self-checking bench for hand_flap_ctrl: directed scenarios plus random frames,
// compared against a frame-level behavioural model.
module tb_hand_flap_ctrl;

    localparam int AVG_DEPTH       = 4;
    localparam int FLAP_THRESH     = 12;
    localparam int COOLDOWN_FRAMES = 6;
    localparam int LOST_FRAMES     = 3;
    localparam int AUTO_FRAMES     = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync_in;
    logic        pos_valid;
    logic [31:0] x_position;
    logic [31:0] y_position;
    logic        flap;
    logic        hand_present;
    logic [8:0]  x_smooth;
    logic [7:0]  y_smooth;
    logic [15:0] flap_cnt;

    always #20 clk = ~clk;

    hand_flap_ctrl #(
        .AVG_DEPTH       (AVG_DEPTH),
        .FLAP_THRESH     (FLAP_THRESH),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .LOST_FRAMES     (LOST_FRAMES),
        .AUTO_FRAMES     (AUTO_FRAMES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync_in     (vsync_in),
        .pos_valid    (pos_valid),
        .x_position   (x_position),
        .y_position   (y_position),
        .flap         (flap),
        .hand_present (hand_present),
        .x_smooth     (x_smooth),
        .y_smooth     (y_smooth),
        .flap_cnt     (flap_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model
    int  m_wx[$];
    int  m_wy[$];
    bit  m_track;
    int  m_cd;
    int  m_miss;
    int  m_auto;
    int  m_flap_cnt;
    int  m_xs;
    int  m_ys;
    bit  m_flap;

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int qavg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / AVG_DEPTH;
    endfunction

    function automatic void model_reset();
        m_wx.delete();
        m_wy.delete();
        m_track    = 1'b0;
        m_cd       = 0;
        m_miss     = 0;
        m_auto     = 0;
        m_flap_cnt = 0;
        m_xs       = 0;
        m_ys       = 0;
        m_flap     = 1'b0;
    endfunction

    function automatic void model_frame(input bit valid, input int x, input int y);
        int cx = clampi(x, 319);
        int cy = clampi(y, 239);
        int prev_ys = m_ys;
        bit in_cd;
        m_flap = 1'b0;
        if (!m_track) begin
            if (valid) begin
                m_wx.delete();
                m_wy.delete();
                for (int i = 0; i < AVG_DEPTH; i++) begin
                    m_wx.push_back(cx);
                    m_wy.push_back(cy);
                end
                m_track = 1'b1;
                m_cd    = 0;
                m_miss  = 0;
                m_auto  = 0;
            end else begin
`ifdef HAND_FLAP_AUTOFLAP_EN
                m_auto++;
                if (m_auto == AUTO_FRAMES) begin
                    m_flap = 1'b1;
                    m_auto = 0;
                end
`endif
            end
        end else begin
            in_cd = (m_cd > 0);
            if (valid) begin
                m_wx.push_front(cx);
                void'(m_wx.pop_back());
                m_wy.push_front(cy);
                void'(m_wy.pop_back());
                m_miss = 0;
            end else begin
                m_miss++;
            end
            if (in_cd) m_cd--;
            if (m_miss == LOST_FRAMES) begin
                m_track = 1'b0;
                m_cd    = 0;
                m_miss  = 0;
            end else if (valid && !in_cd && (prev_ys - qavg(m_wy)) >= FLAP_THRESH) begin
                m_flap = 1'b1;
                m_cd   = COOLDOWN_FRAMES;
            end
        end
        m_xs = m_track ? qavg(m_wx) : 0;
        m_ys = m_track ? qavg(m_wy) : 0;
        if (m_flap) m_flap_cnt = (m_flap_cnt + 1) & 16'hFFFF;
    endfunction

    // One camera frame: vsync rises at a falling clk edge; strobe cycle S follows the
    // third rising edge, smoothed values appear at S+1 and the flap pulse at S+2.
    task automatic frame(input bit valid, input int x, input int y);
        @(negedge clk);
        pos_valid  = valid;
        x_position = x;
        y_position = y;
        vsync_in   = 1'b1;
        model_frame(valid, x, y);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("x_smooth", x_smooth, m_xs);
        check("y_smooth", y_smooth, m_ys);
        check("hand_present", hand_present, m_track);
        check("flap_early", flap, 0);
        @(negedge clk);
        check("flap_pulse", flap, m_flap);
        check("flap_cnt", flap_cnt, m_flap_cnt);
        @(negedge clk);
        vsync_in = 1'b0;
        check("flap_width", flap, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        vsync_in = 1'b0;
        #1;
        check("rst_flap", flap, 0);
        check("rst_present", hand_present, 0);
        check("rst_x", x_smooth, 0);
        check("rst_y", y_smooth, 0);
        check("rst_cnt", flap_cnt, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ry;
        reset      = 1'b1;
        vsync_in   = 1'b0;
        pos_valid  = 1'b0;
        x_position = '0;
        y_position = '0;
        model_reset();
        repeat (3) @(negedge clk);
        apply_reset();

        // Acquisition and steady tracking
        for (int i = 0; i < 5; i++) frame(1'b1, 160, 200);
        check("acq_y", y_smooth, 200);

        // Upward stroke, then frames inside cooldown
        frame(1'b1, 160, 100);
        check("stroke_y", y_smooth, 175);
        check("stroke_cnt", flap_cnt, 1);
        frame(1'b1, 160, 150);
        frame(1'b1, 160, 125);
        frame(1'b1, 160, 100);
        for (int i = 0; i < 4; i++) frame(1'b1, 160, 100);

        // Slow drift
        for (int i = 0; i < 4; i++) frame(1'b1, 160, 200);
        frame(1'b1, 160, 190);
        frame(1'b1, 160, 180);
        frame(1'b1, 160, 180);

        // Misses, recovery, loss and re-acquisition
        frame(1'b0, 0, 0);
        frame(1'b0, 0, 0);
        frame(1'b1, 160, 180);
        for (int i = 0; i < 3; i++) frame(1'b0, 0, 0);
        check("lost_present", hand_present, 0);
        frame(1'b1, 30, 50);
        check("reacq_y", y_smooth, 50);

        // Clamping
        for (int i = 0; i < 4; i++) frame(1'b1, -7, -5);
        check("clamp_low_y", y_smooth, 0);
        for (int i = 0; i < 4; i++) frame(1'b1, 1000, 400);
        check("clamp_hi_x", x_smooth, 319);
        check("clamp_hi_y", y_smooth, 239);

        // Flap into cooldown, then reset mid-cooldown
        frame(1'b1, 100, 0);
        frame(1'b1, 100, 0);
        apply_reset();

        // Idle with no hand for two auto periods
        for (int i = 0; i < 2 * AUTO_FRAMES; i++) frame(1'b0, 0, 0);
`ifdef HAND_FLAP_AUTOFLAP_EN
        check("auto_cnt", flap_cnt, 2);
`else
        check("auto_cnt", flap_cnt, 0);
`endif

        // Random frames
        ry = 120;
        for (int n = 0; n < 300; n++) begin
            bit v;
            int rx;
            v  = ($urandom_range(0, 9) < 8);
            rx = int'($urandom_range(0, 360)) - 20;
            if ($urandom_range(0, 1) == 1) begin
                ry = int'($urandom_range(0, 290)) - 25;
            end else begin
                ry = ry + int'($urandom_range(0, 16)) - 8;
            end
            frame(v, rx, ry);
            if (n == 150) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
